// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the sequence detectors: WIDTH-bit words in, MSB-first bits out on x.
// Optional even-parity trailer bit when SEQ_SER_PARITY_EN is defined (adds the PAR state).
module seq_bit_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef SEQ_SER_PARITY_EN
        , PAR
`endif
    } state_t;

    state_t           state, state_n;
    logic             x_n, x_valid_n, word_done_n;
    logic [WIDTH-2:0] shift, shift_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             accept;
`ifdef SEQ_SER_PARITY_EN
    logic             par, par_n;
`endif

    // Without parity, the last payload cycle doubles as an accept slot for zero-gap streaming.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (state == IDLE)
                in_ready = 1'b1;
`ifndef SEQ_SER_PARITY_EN
            else if (state == SHIFT && cnt == LAST)
                in_ready = 1'b1;
`endif
        end
    end

    assign accept = in_valid && in_ready;
    assign busy   = (state != IDLE);

    always_comb begin
        state_n     = state;
        x_n         = x;
        x_valid_n   = x_valid;
        word_done_n = 1'b0;
        shift_n     = shift;
        cnt_n       = cnt;
`ifdef SEQ_SER_PARITY_EN
        par_n       = par;
`endif
        case (state)
            IDLE: begin
                x_n       = IDLE_BIT;
                x_valid_n = 1'b0;
                if (accept) begin
                    state_n   = SHIFT;
                    x_n       = in_data[WIDTH-1];
                    x_valid_n = 1'b1;
                    shift_n   = in_data[WIDTH-2:0];
                    cnt_n     = 1;
`ifdef SEQ_SER_PARITY_EN
                    par_n     = ^in_data;
`endif
                end
            end
            SHIFT: begin
                if (cnt < LAST) begin
                    x_n     = shift[WIDTH-2];
                    shift_n = shift << 1;
                    cnt_n   = cnt + 1'b1;
`ifndef SEQ_SER_PARITY_EN
                    word_done_n = (cnt_n == LAST);
`endif
                end else begin
`ifdef SEQ_SER_PARITY_EN
                    state_n     = PAR;
                    x_n         = par;
                    x_valid_n   = 1'b1;
                    word_done_n = 1'b1;
`else
                    if (accept) begin
                        x_n       = in_data[WIDTH-1];
                        x_valid_n = 1'b1;
                        shift_n   = in_data[WIDTH-2:0];
                        cnt_n     = 1;
                    end else begin
                        state_n   = IDLE;
                        x_n       = IDLE_BIT;
                        x_valid_n = 1'b0;
                    end
`endif
                end
            end
`ifdef SEQ_SER_PARITY_EN
            PAR: begin
                state_n   = IDLE;
                x_n       = IDLE_BIT;
                x_valid_n = 1'b0;
            end
`endif
            default: begin
                state_n   = IDLE;
                x_n       = IDLE_BIT;
                x_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x         <= IDLE_BIT;
            x_valid   <= 1'b0;
            word_done <= 1'b0;
            shift     <= '0;
            cnt       <= '0;
`ifdef SEQ_SER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            x         <= x_n;
            x_valid   <= x_valid_n;
            word_done <= word_done_n;
            shift     <= shift_n;
            cnt       <= cnt_n;
`ifdef SEQ_SER_PARITY_EN
            par       <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer (WIDTH=8); parity scenario runs when SEQ_SER_PARITY_EN is defined.
module tb_seq_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         x;
    logic         x_valid;
    logic         word_done;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    seq_bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .x_valid   (x_valid),
        .word_done (word_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hE6;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL reset_in_ready[%0d]: got %b want 0", c, in_ready); end
            n_cmp++; if (x !== 1'b0)         begin n_bad++; $display("FAIL reset_x[%0d]: got %b want 0", c, x); end
            n_cmp++; if (x_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_x_valid[%0d]: got %b want 0", c, x_valid); end
            n_cmp++; if (word_done !== 1'b0) begin n_bad++; $display("FAIL reset_word_done[%0d]: got %b want 0", c, word_done); end
            n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", c, busy); end
        end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_no_accept_busy: got %b want 0", busy); end
        n_cmp++; if (x_valid !== 1'b0) begin n_bad++; $display("FAIL reset_no_accept_x_valid: got %b want 0", x_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_word;
        logic [W-1:0] exp_bits;
        exp_bits = 8'b1110_0110;
        in_data = 8'hE6; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= W; i++) begin
            n_cmp++; if (x !== exp_bits[W-i])  begin n_bad++; $display("FAIL single_x[%0d]: got %b want %b", i, x, exp_bits[W-i]); end
            n_cmp++; if (x_valid !== 1'b1)     begin n_bad++; $display("FAIL single_x_valid[%0d]: got %b want 1", i, x_valid); end
            n_cmp++; if (word_done !== (i == W)) begin n_bad++; $display("FAIL single_word_done[%0d]: got %b want %b", i, word_done, (i == W)); end
            tick();
        end
        n_cmp++; if (x !== 1'b0)       begin n_bad++; $display("FAIL single_after_x: got %b want 0", x); end
        n_cmp++; if (x_valid !== 1'b0) begin n_bad++; $display("FAIL single_after_x_valid: got %b want 0", x_valid); end
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL single_after_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [2*W-1:0] stream;
        stream = 16'b1111_0000_0000_1110;
        in_data = 8'hF0; in_valid = 1'b1;
        tick();
        in_data = 8'h0E;
        for (int i = 1; i <= 2*W; i++) begin
            if (i == W + 1) in_valid = 1'b0;
            n_cmp++; if (x !== stream[2*W-i]) begin n_bad++; $display("FAIL b2b_x[%0d]: got %b want %b", i, x, stream[2*W-i]); end
            n_cmp++; if (x_valid !== 1'b1)    begin n_bad++; $display("FAIL b2b_x_valid[%0d]: got %b want 1", i, x_valid); end
            n_cmp++; if (word_done !== (i == W || i == 2*W)) begin n_bad++; $display("FAIL b2b_word_done[%0d]: got %b want %b", i, word_done, (i == W || i == 2*W)); end
            n_cmp++; if (in_ready !== (i == W || i == 2*W))  begin n_bad++; $display("FAIL b2b_in_ready[%0d]: got %b want %b", i, in_ready, (i == W || i == 2*W)); end
            tick();
        end
        n_cmp++; if (x_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_after_x_valid: got %b want 0", x_valid); end
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL b2b_after_busy: got %b want 0", busy); end
    endtask

    task automatic test_stall;
        logic [2*W-1:0] stream;
        stream = {8'h55, 8'hAA};
        in_data = 8'h55; in_valid = 1'b1;
        tick();
        for (int i = 1; i <= 2*W; i++) begin
            if (i == 1)                in_data = 8'hAA;
            else if (i >= 2 && i <= 6) in_data = 8'h3C ^ 8'(i);
            else if (i == 7)           in_data = 8'hAA;
            else if (i == W + 1)       in_valid = 1'b0;
            if (i < W) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
            end
            n_cmp++; if (x !== stream[2*W-i]) begin n_bad++; $display("FAIL stall_x[%0d]: got %b want %b", i, x, stream[2*W-i]); end
            n_cmp++; if (x_valid !== 1'b1)    begin n_bad++; $display("FAIL stall_x_valid[%0d]: got %b want 1", i, x_valid); end
            tick();
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_after_busy: got %b want 0", busy); end
    endtask

    task automatic test_midword_reset;
        logic [W-1:0] exp_bits;
        in_data = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++; if (x !== 1'b1) begin n_bad++; $display("FAIL mrst_x[%0d]: got %b want 1", i, x); end
            if (i < 4) tick();
        end
        rst = 1'b1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mrst_in_ready: got %b want 0", in_ready); end
        tick();
        rst = 1'b0;
        n_cmp++; if (x !== 1'b0)         begin n_bad++; $display("FAIL mrst_x_after: got %b want 0", x); end
        n_cmp++; if (x_valid !== 1'b0)   begin n_bad++; $display("FAIL mrst_x_valid_after: got %b want 0", x_valid); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL mrst_busy_after: got %b want 0", busy); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (word_done !== 1'b0 || x_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_quiet[%0d]: got wd=%b xv=%b want 0/0", i, word_done, x_valid); end
            tick();
        end
        exp_bits = 8'h81;
        in_data = 8'h81; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= W; i++) begin
            n_cmp++; if (x !== exp_bits[W-i]) begin n_bad++; $display("FAIL mrst_new_x[%0d]: got %b want %b", i, x, exp_bits[W-i]); end
            tick();
        end
        repeat (3) tick();
    endtask

`ifdef SEQ_SER_PARITY_EN
    task automatic test_parity;
        logic [W:0] exp_bits;
        exp_bits = {8'h07, 1'b1};
        in_data = 8'h07; in_valid = 1'b1;
        tick();
        in_data = 8'h80;
        for (int i = 1; i <= W + 1; i++) begin
            n_cmp++; if (x !== exp_bits[W+1-i]) begin n_bad++; $display("FAIL par_x[%0d]: got %b want %b", i, x, exp_bits[W+1-i]); end
            n_cmp++; if (x_valid !== 1'b1)      begin n_bad++; $display("FAIL par_x_valid[%0d]: got %b want 1", i, x_valid); end
            n_cmp++; if (word_done !== (i == W + 1)) begin n_bad++; $display("FAIL par_word_done[%0d]: got %b want %b", i, word_done, (i == W + 1)); end
            n_cmp++; if (in_ready !== 1'b0)     begin n_bad++; $display("FAIL par_in_ready[%0d]: got %b want 0", i, in_ready); end
            tick();
        end
        n_cmp++; if (x_valid !== 1'b0)  begin n_bad++; $display("FAIL par_gap_x_valid: got %b want 0", x_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL par_gap_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (x !== 1'b1 || x_valid !== 1'b1) begin n_bad++; $display("FAIL par_next_start: got x=%b xv=%b want 1/1", x, x_valid); end
        repeat (W + 3) tick();
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        test_reset();
`ifdef SEQ_SER_PARITY_EN
        test_parity();
`else
        test_single_word();
        test_back_to_back();
        test_stall();
`endif
        test_midword_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
